mpu_mem_feeder: RTL and testbench
=================================

# mpu_mem_feeder

Memory-side sequencer directly upstream of `mpu_load`. It accepts one whole matrix per request from the host/memory model and checks its dimensions. It then streams the elements row-major, one per cycle, on `mpu_load`'s memory-side inputs and waits for the load acknowledge. It reports completion or failure as a single-cycle pulse.

## Interface
Parameters:
- `FP`, 32: element width (IEEE-754 single).
- `M`, 4: maximum rows; `MBITS = $clog2(M)`.
- `N`, 4: maximum columns; `NBITS = $clog2(N)`.
- `MATRIX_REG_SIZE`, 2: register-file address width.
- `ACK_TIMEOUT`, 64: cycles allowed in WAIT_ACK; used only with the timeout feature.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid_in` in 1: host request valid.
- `req_ready_out` out 1: high only in IDLE.
- `req_matrix_in` in `FP*M*N`: packed elements; element k occupies bits `[k*FP +: FP]`.
- `req_m_size_in` in `MBITS+1`: rows.
- `req_n_size_in` in `NBITS+1`: columns.
- `req_addr_in` in `MATRIX_REG_SIZE`: destination matrix register.
- `load_en_out` out 1: to `mpu_load` `load_en_in`.
- `mem_element_out` out `FP`: to `mem_element_in`.
- `mem_m_size_out` out `MBITS+1`: to `mem_m_size_in`.
- `mem_n_size_out` out `NBITS+1`: to `mem_n_size_in`.
- `mem_load_addr_out` out `MATRIX_REG_SIZE`: to `mem_load_addr_in`.
- `mem_load_ack_in` in 1: from `mem_load_ack_out`.
- `mem_load_error_in` in 1: from `mem_load_error_out`.
- `done_out` out 1: one-cycle pulse on successful load.
- `error_out` out 1: one-cycle pulse on rejected or aborted load.

## Operation
- States are IDLE, STREAM, WAIT_ACK, DONE and ERR.
- **IDLE:** `req_ready_out`=1. When `req_valid_in` is high, latch the matrix, sizes and address into internal registers.
  - If 1≤m≤M and 1≤n≤N, go to STREAM with index k=0.
  - Otherwise go to ERR; `load_en_out` is never raised.
- **STREAM:**
  - `load_en_out`=1 and `mem_element_out`=buffer[k], where k = i*n + j (compact row-major; a 2×2 matrix uses elements 0..3).
  - Sizes and address are driven from the latched copies and stay constant.
  - j increments each cycle; at j=n-1 it wraps to 0 and i increments.
  - After element m*n-1 is driven, go to WAIT_ACK.
  - `mem_load_ack_in` is ignored in this state.
- **WAIT_ACK:** `load_en_out`=0 and the sizes/address hold.
  - Ack → DONE.
  - Error → ERR.
  - Error has priority over ack in the same cycle.
- `mem_load_error_in` in STREAM aborts immediately to ERR.
- **DONE:** pulse `done_out`, then go to IDLE.
- **ERR:** pulse `error_out`, then go to IDLE.
- Requests arriving outside IDLE are not accepted (`req_ready_out`=0); the host holds `req_valid_in`.

## Timing
- Reset values: `req_ready_out`=1 and every other output 0. State is IDLE, counters are 0 and the buffer is cleared.
- For a request accepted at edge T, element 0 appears after T and element m*n-1 after T+m*n-1.
- `load_en_out` is high for exactly m*n consecutive cycles.
- `done_out` is asserted one cycle after the ack is sampled. Minimum accept-to-done is m*n+2 cycles.
- A size reject gives `error_out` in the cycle after acceptance.
- `rst` mid-operation returns to IDLE on the next edge with no done/error pulse. `load_en_out` drops that edge.
- Back-to-back requests: the next accept is possible in the IDLE cycle following DONE/ERR.

## Configuration
- `MPU_FEEDER_TIMEOUT_EN` defined: a WAIT_ACK cycle counter runs.
  - Reaching `ACK_TIMEOUT` cycles without ack/error → ERR.
  - The counter clears on entry to WAIT_ACK.
- `MPU_FEEDER_TIMEOUT_EN` undefined: there is no counter and WAIT_ACK waits indefinitely.

## Structure
- `mpu_pkg` holds:
  - `mpu_feeder_state_t` (IDLE, STREAM, WAIT_ACK, DONE, ERR);
  - `ACK_TIMEOUT` default.
- `FP`, `M`, `N`, `MBITS`, `NBITS` and `MATRIX_REG_SIZE` come from `global_defs`.
- One sub-module, `mpu_feed_index_counter`:
  - i/j counter with clear, enable, n-wrap and a `last` flag;
  - produces k = i*n + j.

## Test plan
- **2×2 load:** request {1.0, 50.33, -2.5, 0.125}, addr 0, with ack two cycles after the last element.
  - Expect `mem_element_out` = 3f800000, 424951ec, c0200000, 3e000000 on 4 consecutive `load_en_out` cycles.
  - Expect `done_out` pulse; the register file then reads back the same values.
- **Size reject:** m=0, n=2, and separately m=M+1.
  - Expect `error_out` pulse one cycle after accept and `load_en_out` never high.
- **Error mid-stream:** `mem_load_error_in` on element 2 of a 3×3 load.
  - Expect `load_en_out` low the next cycle, one `error_out` pulse and no `done_out`.
- **Ack/error collision:** ack and error together in WAIT_ACK.
  - Expect `error_out`; `done_out` stays 0.
- **Reset mid-stream:** `rst` during element 1.
  - Expect all outputs 0, `req_ready_out`=1, no pulses; the following 1×4 load completes normally.
- **Timeout (`MPU_FEEDER_TIMEOUT_EN` defined, `ACK_TIMEOUT`=8):** no ack.
  - Expect `error_out` exactly 9 cycles after WAIT_ACK entry.

Source files
------------

// File: rtl/global_defs.sv
// Shared matrix geometry for the MPU datapath: element width, maximum
// dimensions and register-file address width.
package global_defs;
    localparam int FP              = 32;
    localparam int M               = 4;
    localparam int N               = 4;
    localparam int MBITS           = $clog2(M);
    localparam int NBITS           = $clog2(N);
    localparam int MATRIX_REG_SIZE = 2;
endpackage

// File: rtl/mpu_pkg.sv
// Types and defaults for the MPU memory feeder sequencer.
package mpu_pkg;
    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        WAIT_ACK,
        DONE,
        ERR
    } mpu_feeder_state_t;

    localparam int ACK_TIMEOUT_DEFAULT = 64;
endpackage

// File: rtl/mpu_feed_index_counter.sv
// Row-major i/j walker over an m x n matrix; k tracks i*n + j as a running
// linear index so no multiplier is needed.
module mpu_feed_index_counter #(
    parameter int MBITS = 2,
    parameter int NBITS = 2,
    parameter int KW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [MBITS:0]   m_size,
    input  logic [NBITS:0]   n_size,
    output logic [KW-1:0]    k,
    output logic             last
);
    logic [MBITS:0] i_q;
    logic [NBITS:0] j_q;
    logic [KW-1:0]  k_q;
    logic [MBITS:0] i_last;
    logic [NBITS:0] j_last;
    logic           j_wrap;

    assign i_last = m_size - (MBITS+1)'(1);
    assign j_last = n_size - (NBITS+1)'(1);
    assign j_wrap = (j_q == j_last);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else if (en) begin
            k_q <= k_q + KW'(1);
            if (j_wrap) begin
                j_q <= '0;
                i_q <= i_q + (MBITS+1)'(1);
            end else begin
                j_q <= j_q + (NBITS+1)'(1);
            end
        end
    end

    assign k    = k_q;
    assign last = (i_q == i_last) && j_wrap;
endmodule

// File: rtl/mpu_mem_feeder.sv
// Streams one latched matrix row-major into mpu_load and waits for its ack.
// Optional WAIT_ACK timeout enabled by defining MPU_FEEDER_TIMEOUT_EN.
module mpu_mem_feeder
    import mpu_pkg::*;
#(
    parameter int FP              = global_defs::FP,
    parameter int M               = global_defs::M,
    parameter int N               = global_defs::N,
    parameter int MBITS           = $clog2(M),
    parameter int NBITS           = $clog2(N),
    parameter int MATRIX_REG_SIZE = global_defs::MATRIX_REG_SIZE,
    parameter int ACK_TIMEOUT     = ACK_TIMEOUT_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid_in,
    output logic                       req_ready_out,
    input  logic [FP*M*N-1:0]          req_matrix_in,
    input  logic [MBITS:0]             req_m_size_in,
    input  logic [NBITS:0]             req_n_size_in,
    input  logic [MATRIX_REG_SIZE-1:0] req_addr_in,
    output logic                       load_en_out,
    output logic [FP-1:0]              mem_element_out,
    output logic [MBITS:0]             mem_m_size_out,
    output logic [NBITS:0]             mem_n_size_out,
    output logic [MATRIX_REG_SIZE-1:0] mem_load_addr_out,
    input  logic                       mem_load_ack_in,
    input  logic                       mem_load_error_in,
    output logic                       done_out,
    output logic                       error_out
);
    localparam int KW = (M * N > 1) ? $clog2(M * N) : 1;

    mpu_feeder_state_t state_q, state_d;

    logic [FP*M*N-1:0]          buf_q;
    logic [MBITS:0]             m_q;
    logic [NBITS:0]             n_q;
    logic [MATRIX_REG_SIZE-1:0] addr_q;

    logic          accept;
    logic          size_ok;
    logic          streaming;
    logic          holding;
    logic          last;
    logic          timeout;
    logic [KW-1:0] k;

    assign accept  = (state_q == IDLE) && req_valid_in;
    assign size_ok = (req_m_size_in != '0) && (req_m_size_in <= (MBITS+1)'(M)) &&
                     (req_n_size_in != '0) && (req_n_size_in <= (NBITS+1)'(N));

    // NOTE: the matrix buffer is reset explicitly because a cleared buffer is
    // part of the defined reset state, not just the control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            m_q     <= '0;
            n_q     <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                buf_q  <= req_matrix_in;
                m_q    <= req_m_size_in;
                n_q    <= req_n_size_in;
                addr_q <= req_addr_in;
            end
        end
    end

    mpu_feed_index_counter #(
        .MBITS (MBITS),
        .NBITS (NBITS),
        .KW    (KW)
    ) u_index (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q == IDLE),
        .en     (streaming),
        .m_size (m_q),
        .n_size (n_q),
        .k      (k),
        .last   (last)
    );

`ifdef MPU_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    logic [TW-1:0] wait_cnt_q;

    // Held at zero outside WAIT_ACK, so every entry starts a fresh count.
    always_ff @(posedge clk) begin
        if (rst || state_q != WAIT_ACK) begin
            wait_cnt_q <= '0;
        end else if (wait_cnt_q != TW'(ACK_TIMEOUT)) begin
            wait_cnt_q <= wait_cnt_q + TW'(1);
        end
    end

    assign timeout = (wait_cnt_q == TW'(ACK_TIMEOUT));
`else
    logic unused_ack_timeout;
    assign unused_ack_timeout = ^ACK_TIMEOUT;
    assign timeout            = 1'b0;
`endif

    // NOTE: state_d takes a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (req_valid_in) state_d = size_ok ? STREAM : ERR;
            STREAM: begin
                if (mem_load_error_in) state_d = ERR;
                else if (last)         state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (mem_load_error_in)    state_d = ERR;
                else if (mem_load_ack_in) state_d = DONE;
                else if (timeout)         state_d = ERR;
            end
            DONE:     state_d = IDLE;
            ERR:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    assign streaming = (state_q == STREAM);
    assign holding   = streaming || (state_q == WAIT_ACK);

    assign req_ready_out     = (state_q == IDLE);
    assign load_en_out       = streaming;
    assign mem_element_out   = streaming ? buf_q[k*FP +: FP] : '0;
    assign mem_m_size_out    = holding ? m_q : '0;
    assign mem_n_size_out    = holding ? n_q : '0;
    assign mem_load_addr_out = holding ? addr_q : '0;
    assign done_out          = (state_q == DONE);
    assign error_out         = (state_q == ERR);
endmodule

// File: tb/tb_mpu_mem_feeder.sv
// Self-checking bench for mpu_mem_feeder: a per-transaction trace model
// predicts every output cycle by cycle, plus literal spot checks.
module tb_mpu_mem_feeder;
    localparam int FP    = 32;
    localparam int M     = 4;
    localparam int N     = 4;
    localparam int MBITS = 2;
    localparam int NBITS = 2;
    localparam int AW    = 2;
    localparam int TB_TO = 8;
`ifdef MPU_FEEDER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid_in;
    logic              req_ready_out;
    logic [FP*M*N-1:0] req_matrix_in;
    logic [MBITS:0]    req_m_size_in;
    logic [NBITS:0]    req_n_size_in;
    logic [AW-1:0]     req_addr_in;
    logic              load_en_out;
    logic [FP-1:0]     mem_element_out;
    logic [MBITS:0]    mem_m_size_out;
    logic [NBITS:0]    mem_n_size_out;
    logic [AW-1:0]     mem_load_addr_out;
    logic              mem_load_ack_in;
    logic              mem_load_error_in;
    logic              done_out;
    logic              error_out;

    mpu_mem_feeder #(
        .FP(FP), .M(M), .N(N), .MBITS(MBITS), .NBITS(NBITS),
        .MATRIX_REG_SIZE(AW), .ACK_TIMEOUT(TB_TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid_in      (req_valid_in),
        .req_ready_out     (req_ready_out),
        .req_matrix_in     (req_matrix_in),
        .req_m_size_in     (req_m_size_in),
        .req_n_size_in     (req_n_size_in),
        .req_addr_in       (req_addr_in),
        .load_en_out       (load_en_out),
        .mem_element_out   (mem_element_out),
        .mem_m_size_out    (mem_m_size_out),
        .mem_n_size_out    (mem_n_size_out),
        .mem_load_addr_out (mem_load_addr_out),
        .mem_load_ack_in   (mem_load_ack_in),
        .mem_load_error_in (mem_load_error_in),
        .done_out          (done_out),
        .error_out         (error_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           ready;
        logic           load_en;
        logic           done;
        logic           err;
        logic [FP-1:0]  elem;
        logic [MBITS:0] m;
        logic [NBITS:0] n;
        logic [AW-1:0]  addr;
    } out_t;

    out_t exp_q;
    bit   exp_on = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   load_cnt = 0;
    logic [FP-1:0] seen[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic out_t idle_out();
        out_t o;
        o = '0;
        o.ready = 1'b1;
        return o;
    endfunction

    // Single compare point for the cycle-level model.
    always @(negedge clk) begin
        out_t act;
        act = '{req_ready_out, load_en_out, done_out, error_out, mem_element_out,
                mem_m_size_out, mem_n_size_out, mem_load_addr_out};
        if (exp_on) check($sformatf("cycle%0d", cyc), 64'(act), 64'(exp_q));
        if (done_out === 1'b1) done_cnt++;
        if (error_out === 1'b1) err_cnt++;
        if (load_en_out === 1'b1) begin
            load_cnt++;
            seen.push_back(mem_element_out);
        end
    end

    always @(posedge clk) cyc++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FP*M*N-1:0] rand_matrix();
        logic [FP*M*N-1:0] r;
        for (int i = 0; i < M * N; i++) r[i*FP +: FP] = $urandom;
        return r;
    endfunction

    // Inputs while the feeder is busy must not matter.
    task automatic busy_noise();
        req_valid_in  = 1'($urandom_range(0, 1));
        req_matrix_in = rand_matrix();
        req_m_size_in = (MBITS+1)'($urandom);
        req_n_size_in = (NBITS+1)'($urandom);
        req_addr_in   = AW'($urandom);
    endtask

    // Drives one request starting in an IDLE cycle and predicts every output
    // cycle from the behavioural rules. Returns in the following IDLE cycle.
    task automatic run_txn(input int m, input int n, input int addr,
                           input logic [FP*M*N-1:0] mat, input int d,
                           input int err_elem, input bit collide, input int rst_elem);
        out_t e;
        bit   ok;
        bit   timed_out;
        ok = (m >= 1) && (m <= M) && (n >= 1) && (n <= N);
        req_valid_in      = 1'b1;
        req_matrix_in     = mat;
        req_m_size_in     = (MBITS+1)'(m);
        req_n_size_in     = (NBITS+1)'(n);
        req_addr_in       = AW'(addr);
        mem_load_ack_in   = 1'b0;
        mem_load_error_in = 1'b0;
        exp_q = idle_out();
        step();
        busy_noise();
        if (!ok) begin
            e = '0;
            e.err = 1'b1;
            exp_q = e;
            step();
            req_valid_in = 1'b0;
            return;
        end
        for (int k = 0; k < m * n; k++) begin
            e = '0;
            e.load_en = 1'b1;
            e.elem    = mat[k*FP +: FP];
            e.m       = (MBITS+1)'(m);
            e.n       = (NBITS+1)'(n);
            e.addr    = AW'(addr);
            mem_load_ack_in   = 1'($urandom_range(0, 1));
            mem_load_error_in = (k == err_elem);
            rst               = (k == rst_elem);
            exp_q = e;
            step();
            busy_noise();
            if (k == rst_elem) begin
                rst = 1'b0;
                mem_load_ack_in = 1'b0;
                mem_load_error_in = 1'b0;
                req_valid_in = 1'b0;
                exp_q = idle_out();
                step();
                return;
            end
            if (k == err_elem) begin
                mem_load_ack_in = 1'b0;
                mem_load_error_in = 1'b0;
                e = '0;
                e.err = 1'b1;
                exp_q = e;
                step();
                req_valid_in = 1'b0;
                return;
            end
        end
        timed_out = 1'b0;
        for (int w = 1; ; w++) begin
            e = '0;
            e.m    = (MBITS+1)'(m);
            e.n    = (NBITS+1)'(n);
            e.addr = AW'(addr);
            mem_load_ack_in   = (w == d);
            mem_load_error_in = collide && (w == d);
            exp_q = e;
            step();
            busy_noise();
            if (w == d) break;
            if (TO_EN && w == TB_TO + 1) begin
                timed_out = 1'b1;
                break;
            end
        end
        mem_load_ack_in   = 1'b0;
        mem_load_error_in = 1'b0;
        e = '0;
        if (collide || timed_out) e.err = 1'b1;
        else                      e.done = 1'b1;
        exp_q = e;
        step();
        req_valid_in = 1'b0;
    endtask

    task automatic idle_gap(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            req_valid_in      = 1'b0;
            mem_load_ack_in   = 1'($urandom_range(0, 1));
            mem_load_error_in = 1'($urandom_range(0, 1));
            exp_q = idle_out();
            step();
        end
        mem_load_ack_in   = 1'b0;
        mem_load_error_in = 1'b0;
    endtask

    initial begin
        logic [FP*M*N-1:0] mat;
        int d0, e0, l0;
        rst = 1'b1;
        req_valid_in = 1'b0;
        req_matrix_in = '0;
        req_m_size_in = '0;
        req_n_size_in = '0;
        req_addr_in = '0;
        mem_load_ack_in = 1'b0;
        mem_load_error_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q = idle_out();
        exp_on = 1'b1;
        check("reset_ready", 64'(req_ready_out), 64'd1);
        check("reset_load_en", 64'(load_en_out), 64'd0);
        step();
        rst = 1'b0;
        idle_gap(2);

        // 2x2 load with literal element values, ack two cycles after the last element.
        mat = rand_matrix();
        mat[0*FP +: FP] = 32'h3f800000;
        mat[1*FP +: FP] = 32'h424951ec;
        mat[2*FP +: FP] = 32'hc0200000;
        mat[3*FP +: FP] = 32'h3e000000;
        seen.delete();
        d0 = done_cnt;
        run_txn(2, 2, 0, mat, 2, -1, 1'b0, -1);
        check("lit_count", 64'(seen.size()), 64'd4);
        check("lit_e0", 64'(seen[0]), 64'h3f800000);
        check("lit_e1", 64'(seen[1]), 64'h424951ec);
        check("lit_e2", 64'(seen[2]), 64'hc0200000);
        check("lit_e3", 64'(seen[3]), 64'h3e000000);
        check("lit_done", 64'(done_cnt - d0), 64'd1);

        // Size rejects: never any load_en, one error pulse each.
        l0 = load_cnt;
        e0 = err_cnt;
        run_txn(0, 2, 1, rand_matrix(), 1, -1, 1'b0, -1);
        run_txn(M + 1, 2, 2, rand_matrix(), 1, -1, 1'b0, -1);
        check("reject_load_en", 64'(load_cnt - l0), 64'd0);
        check("reject_err", 64'(err_cnt - e0), 64'd2);

        // Error on element 2 of a 3x3 load.
        idle_gap(1);
        l0 = load_cnt;
        e0 = err_cnt;
        d0 = done_cnt;
        run_txn(3, 3, 3, rand_matrix(), 1, 2, 1'b0, -1);
        check("abort_load_en", 64'(load_cnt - l0), 64'd3);
        check("abort_err", 64'(err_cnt - e0), 64'd1);
        check("abort_done", 64'(done_cnt - d0), 64'd0);

        // Ack and error together in WAIT_ACK.
        d0 = done_cnt;
        run_txn(2, 3, 1, rand_matrix(), 3, -1, 1'b1, -1);
        check("collide_done", 64'(done_cnt - d0), 64'd0);

        // Reset during element 1, then a 1x4 load completes.
        d0 = done_cnt;
        e0 = err_cnt;
        run_txn(2, 2, 2, rand_matrix(), 1, -1, 1'b0, 1);
        check("rst_no_pulse", 64'(done_cnt - d0 + err_cnt - e0), 64'd0);
        run_txn(1, 4, 3, rand_matrix(), 1, -1, 1'b0, -1);
        check("post_rst_done", 64'(done_cnt - d0), 64'd1);

        // Long silence in WAIT_ACK: timeout when enabled, otherwise a late ack.
        run_txn(1, 2, 0, rand_matrix(), 40, -1, 1'b0, -1);

        // Randomized traffic, including back-to-back requests.
        for (int t = 0; t < 40; t++) begin
            int m, n, ee;
            if ($urandom_range(0, 7) == 0) begin
                m = $urandom_range(0, M + 1);
                n = ($urandom_range(0, 1) != 0) ? 0 : N + 1;
            end else begin
                m = $urandom_range(1, M);
                n = $urandom_range(1, N);
            end
            ee = ($urandom_range(0, 6) == 0) ? $urandom_range(0, M * N - 1) : -1;
            run_txn(m, n, $urandom_range(0, 3), rand_matrix(), $urandom_range(1, 5),
                    ee, ($urandom_range(0, 9) == 0), -1);
            if ($urandom_range(0, 1) != 0) idle_gap($urandom_range(1, 3));
        end

        idle_gap(2);
        exp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
